// File: rtl/dfdd_pkg.sv
// Shared types and constants for the fp16 horizontal window generator slice.
package dfdd_pkg;

  localparam int FP16_EXP_WIDTH  = 5;
  localparam int FP16_FRAC_WIDTH = 10;
  localparam int FP16_WIDTH      = 1 + FP16_EXP_WIDTH + FP16_FRAC_WIDTH;

  typedef logic [FP16_WIDTH-1:0] fp16_t;

  localparam fp16_t FP16_ZERO = '0;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    RUN,
    FLUSH
  } win_state_e;

endpackage

// File: rtl/window_shift_reg.sv
// W-tap shift register. A row-start load fills every tap but the top one with the pad
// value; a shift moves taps towards index 0 and the new value enters the top tap.
module window_shift_reg #(
  parameter int DATA_W = 16,
  parameter int TAPS   = 9
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic              shift_i,
  input  logic [DATA_W-1:0] pad_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] taps_o [TAPS]
);

  logic [DATA_W-1:0] taps_q [TAPS];
  logic [DATA_W-1:0] taps_d [TAPS];

  always_comb begin
    taps_d = taps_q;
    if (load_i) begin
      for (int i = 0; i < TAPS-1; i++) taps_d[i] = pad_i;
      taps_d[TAPS-1] = data_i;
    end else if (shift_i) begin
      for (int i = 0; i < TAPS-1; i++) taps_d[i] = taps_q[i+1];
      taps_d[TAPS-1] = data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < TAPS; i++) taps_q[i] <= '0;
    end else begin
      taps_q <= taps_d;
    end
  end

  assign taps_o = taps_q;

endmodule

// File: rtl/window_gen_h_fp16.sv
// Horizontal sliding-window generator for an fp16 raster stream with border padding.
// Define WINDOW_GEN_REPLICATE_EN to pad with the edge pixels instead of fp +0.
module window_gen_h_fp16
  import dfdd_pkg::*;
#(
  parameter  int EXP_WIDTH    = FP16_EXP_WIDTH,
  parameter  int FRAC_WIDTH   = FP16_FRAC_WIDTH,
  parameter  int WINDOW_WIDTH = 9,
  parameter  int IMAGE_WIDTH  = 640,
  localparam int FP_WIDTH_REG = 1 + EXP_WIDTH + FRAC_WIDTH
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [FP_WIDTH_REG-1:0] pixel_i,
  input  logic [15:0]             col_i,
  input  logic [15:0]             row_i,
  input  logic                    valid_i,
  output logic [FP_WIDTH_REG-1:0] window_o [1][WINDOW_WIDTH],
  output logic [15:0]             col_o,
  output logic [15:0]             row_o,
  output logic                    valid_o,
  output logic                    overrun_o
);

  localparam int          HALF   = (WINDOW_WIDTH - 1) / 2;
  localparam logic [15:0] HALF_C = 16'(HALF);
  localparam logic [15:0] LAST_C = 16'(IMAGE_WIDTH - 1);

  win_state_e state_q;
  logic [15:0] cnt_q;
  logic [15:0] flush_q;
  logic [15:0] col_q;
  logic [15:0] row_q;
  logic        valid_q;
  logic        overrun_q;

  logic row_start;
  logic accept;
  logic flush_step;
  logic [FP_WIDTH_REG-1:0] left_pad;
  logic [FP_WIDTH_REG-1:0] right_pad;
  logic [FP_WIDTH_REG-1:0] shift_data;
  logic [FP_WIDTH_REG-1:0] taps [WINDOW_WIDTH];

  // A col 0 pixel arriving during flush wins over the remaining flush steps.
  assign row_start  = valid_i && (col_i == 16'd0) && (state_q == IDLE || state_q == FLUSH);
  assign accept     = valid_i && (state_q == FILL || state_q == RUN);
  assign flush_step = (state_q == FLUSH) && !row_start;

`ifdef WINDOW_GEN_REPLICATE_EN
  logic [FP_WIDTH_REG-1:0] pad_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pad_q <= '0;
    end else if (accept && state_q == RUN && col_i == LAST_C) begin
      pad_q <= pixel_i;
    end
  end

  assign left_pad  = pixel_i;
  assign right_pad = pad_q;
`else
  assign left_pad  = '0;
  assign right_pad = '0;
`endif

  assign shift_data = flush_step ? right_pad : pixel_i;

  window_shift_reg #(
    .DATA_W (FP_WIDTH_REG),
    .TAPS   (WINDOW_WIDTH)
  ) u_shift (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load_i  (row_start),
    .shift_i (accept || flush_step),
    .pad_i   (left_pad),
    .data_i  (shift_data),
    .taps_o  (taps)
  );

  // cnt_q holds the column of the next pixel expected in the current row.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      flush_q   <= '0;
      col_q     <= '0;
      row_q     <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (row_start) begin
            state_q <= FILL;
            cnt_q   <= 16'd1;
            row_q   <= row_i;
          end else if (valid_i) begin
            overrun_q <= 1'b1;
          end
        end
        FILL: begin
          if (accept) begin
            cnt_q <= cnt_q + 16'd1;
            if (cnt_q == HALF_C) begin
              valid_q <= 1'b1;
              col_q   <= 16'd0;
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          if (accept) begin
            cnt_q   <= cnt_q + 16'd1;
            valid_q <= 1'b1;
            col_q   <= cnt_q - HALF_C;
            if (col_i == LAST_C) begin
              state_q <= FLUSH;
              flush_q <= 16'd0;
            end
          end
        end
        FLUSH: begin
          if (row_start) begin
            overrun_q <= 1'b1;
            state_q   <= FILL;
            cnt_q     <= 16'd1;
            row_q     <= row_i;
          end else begin
            if (valid_i) overrun_q <= 1'b1;
            valid_q <= 1'b1;
            col_q   <= col_q + 16'd1;
            flush_q <= flush_q + 16'd1;
            if (flush_q == HALF_C - 16'd1) state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < WINDOW_WIDTH; i++) begin : g_win
    assign window_o[0][i] = taps[i];
  end

  assign col_o     = col_q;
  assign row_o     = row_q;
  assign valid_o   = valid_q;
  assign overrun_o = overrun_q;

endmodule

// File: tb/tb_window_gen_h_fp16.sv
// Self-checking bench for window_gen_h_fp16 at IMAGE_WIDTH=16, WINDOW_WIDTH=9.
// Expected padding follows WINDOW_GEN_REPLICATE_EN when the bench is built with it.
module tb_window_gen_h_fp16;

  localparam int IW   = 16;
  localparam int WW   = 9;
  localparam int HALF = (WW - 1) / 2;
  localparam int FPW  = 16;

  logic           clk_i = 1'b0;
  logic           rst_i;
  logic [FPW-1:0] pixel_i;
  logic [15:0]    col_i;
  logic [15:0]    row_i;
  logic           valid_i;
  logic [FPW-1:0] window_o [1][WW];
  logic [15:0]    col_o;
  logic [15:0]    row_o;
  logic           valid_o;
  logic           overrun_o;

  int nAsserts = 0;
  int nFail    = 0;

  logic [FPW-1:0] pix [IW];
  logic [15:0]    curRow;

  always #5 clk_i = ~clk_i;

  window_gen_h_fp16 #(
    .EXP_WIDTH    (5),
    .FRAC_WIDTH   (10),
    .WINDOW_WIDTH (WW),
    .IMAGE_WIDTH  (IW)
  ) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .pixel_i   (pixel_i),
    .col_i     (col_i),
    .row_i     (row_i),
    .valid_i   (valid_i),
    .window_o  (window_o),
    .col_o     (col_o),
    .row_o     (row_o),
    .valid_o   (valid_o),
    .overrun_o (overrun_o)
  );

  // fp16 encoding of a small positive integer n (1..1024).
  function automatic logic [FPW-1:0] fp16Int(input int n);
    int e;
    int mant;
    e = 0;
    while ((n >> (e + 1)) != 0) e++;
    mant = (n - (1 << e)) << (10 - e);
    return 16'(((e + 15) << 10) | mant);
  endfunction

  // Reference value of tap j of the window centred on column c.
  function automatic logic [FPW-1:0] expTap(input int c, input int j);
    int src;
    src = c - HALF + j;
`ifdef WINDOW_GEN_REPLICATE_EN
    if (src < 0) return pix[0];
    if (src >= IW) return pix[IW-1];
`else
    if (src < 0 || src >= IW) return '0;
`endif
    return pix[src];
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkWindow(input int c);
    checkOutput($sformatf("valid c%0d", c), 32'(valid_o), 32'd1);
    checkOutput($sformatf("col c%0d", c), 32'(col_o), 32'(c));
    checkOutput($sformatf("row c%0d", c), 32'(row_o), 32'(curRow));
    for (int j = 0; j < WW; j++)
      checkOutput($sformatf("tap%0d c%0d", j, c), 32'(window_o[0][j]), 32'(expTap(c, j)));
  endtask

  task automatic checkReset();
    checkOutput("rst valid", 32'(valid_o), 32'd0);
    checkOutput("rst overrun", 32'(overrun_o), 32'd0);
    checkOutput("rst col", 32'(col_o), 32'd0);
    checkOutput("rst row", 32'(row_o), 32'd0);
    for (int j = 0; j < WW; j++)
      checkOutput($sformatf("rst tap%0d", j), 32'(window_o[0][j]), 32'd0);
  endtask

  task automatic applyStimulus(input logic v, input int col, input logic [FPW-1:0] p);
    valid_i = v;
    col_i   = 16'(col);
    pixel_i = p;
    row_i   = curRow;
    @(posedge clk_i);
    #1;
  endtask

  // Drives nCols pixels of a row, then tail idle cycles, checking every cycle.
  task automatic runRow(input int rowNum, input bit randPix, input bit gaps,
                        input int nCols, input int tail);
    curRow = 16'(rowNum);
    for (int k = 0; k < IW; k++)
      pix[k] = randPix ? 16'($urandom) : fp16Int(k + 1);
    for (int k = 0; k < nCols; k++) begin
      if (gaps) begin
        for (int g = 0; g < 3 && $urandom_range(1, 0) == 1; g++) begin
          applyStimulus(1'b0, 0, '0);
          checkOutput($sformatf("gap before col %0d", k), 32'(valid_o), 32'd0);
        end
      end
      applyStimulus(1'b1, k, pix[k]);
      if (k >= HALF) checkWindow(k - HALF);
      else checkOutput($sformatf("fill col %0d", k), 32'(valid_o), 32'd0);
    end
    for (int t = 1; t <= tail; t++) begin
      applyStimulus(1'b0, 0, '0);
      if (t <= HALF && nCols == IW) checkWindow(IW - 1 - HALF + t);
      else checkOutput($sformatf("blank %0d", t), 32'(valid_o), 32'd0);
    end
    valid_i = 1'b0;
  endtask

  initial begin
    rst_i   = 1'b0;
    valid_i = 1'b0;
    col_i   = '0;
    row_i   = '0;
    pixel_i = '0;
    curRow  = '0;

    $display("[TB] reset with valid_i toggling");
    for (int i = 0; i < 6; i++) begin
      valid_i = i[0];
      col_i   = '0;
      pixel_i = 16'h3C00;
      @(posedge clk_i);
      #1;
      checkReset();
    end
    valid_i = 1'b0;
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;

    $display("[TB] ramp row back-to-back");
    runRow(3, 1'b0, 1'b0, IW, 8);
    checkOutput("overrun after ramp", 32'(overrun_o), 32'd0);

    $display("[TB] ramp row with random gaps");
    runRow(4, 1'b0, 1'b1, IW, 8);

    $display("[TB] random pixels with random gaps");
    runRow(7, 1'b1, 1'b1, IW, 8);
    runRow(10, 1'b1, 1'b0, IW, 6);
    checkOutput("overrun after clean rows", 32'(overrun_o), 32'd0);

    $display("[TB] next row starts during flush");
    runRow(5, 1'b0, 1'b0, IW, 2);
    checkOutput("overrun before early row", 32'(overrun_o), 32'd0);
    runRow(6, 1'b0, 1'b0, IW, 8);
    checkOutput("overrun after early row", 32'(overrun_o), 32'd1);

    $display("[TB] reset mid-row");
    runRow(8, 1'b0, 1'b0, 10, 0);
    rst_i = 1'b0;
    #1;
    checkReset();
    @(posedge clk_i);
    #1;
    checkReset();
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    runRow(9, 1'b0, 1'b0, IW, 8);
    checkOutput("overrun after reset row", 32'(overrun_o), 32'd0);

    $display("[TB] stray pixel while idle");
    applyStimulus(1'b1, 5, 16'h4500);
    checkOutput("stray valid", 32'(valid_o), 32'd0);
    checkOutput("stray overrun", 32'(overrun_o), 32'd1);
    valid_i = 1'b0;
    @(posedge clk_i);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule
